tieoff_bus_checker: RTL and testbench
=====================================

Name: tieoff_bus_checker

Overview:
- Receiving-end monitor for the constant tie-off output bus driven elsewhere in the design; all 40 lines of that bus are held at 0.
- Samples a WIDTH-bit bus every clock over a programmed window and compares each sample against the constant EXPECT.
- Reports pass/fail, a saturating mismatch count, the first offending sample and its bits, and a sticky OR of all bits that ever mismatched.
- Used in bring-up and self-test to prove the tie-off bus is wired and holding.

Parameters:
- WIDTH, 40, width of the monitored bus.
- EXPECT, {WIDTH{1'b0}}, constant value the bus must hold.
- CNT_W, 16, width of window length, sample index and error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a check window; honoured only in IDLE.
- win_len  input  CNT_W  number of samples in the window; captured when start is accepted.
- bus_in  input  WIDTH  monitored bus.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- pass  output  1  high when the last window had zero mismatches; valid from DONE until the next accepted start.
- err_cnt  output  CNT_W  number of mismatching samples; saturates at all-ones.
- first_err_idx  output  CNT_W  0-based sample index of the first mismatch.
- first_err_bits  output  WIDTH  bus_in^EXPECT at the first mismatch.
- err_bits_acc  output  WIDTH  OR of bus_in^EXPECT over all samples in the window.

Behaviour:
- Reset (clk edge with rst=1):
  - state goes to IDLE.
  - All outputs and internal counters go to 0, including pass.
  - rst has priority over all other inputs in every state.
- States: IDLE, RUN, DONE.
- IDLE:
  - When start=1: capture win_len into len_q, clear sample_cnt, err_cnt, first_err_idx, first_err_bits, err_bits_acc and pass, and clear an internal seen_err flag.
  - If win_len≠0, go to RUN; if win_len=0, go to DONE with pass=1.
- RUN:
  - busy=1; one sample per clock edge; no input register stage.
  - mism = |(bus_in^EXPECT).
  - If mism:
    - err_cnt increments, holding at 2^CNT_W−1.
    - err_bits_acc |= bus_in^EXPECT.
    - If seen_err=0: load first_err_idx=sample_cnt and first_err_bits=bus_in^EXPECT, then set seen_err.
  - At the edge where sample_cnt==len_q−1, go to DONE; otherwise sample_cnt increments.
  - pass is loaded on entry to DONE: 1 if no mismatch was seen, including the final sample.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - start is ignored in DONE.
- Latency: with start accepted at edge E0, samples are taken at edges E1..EN and done is high in the cycle after EN.
- start is ignored while busy; win_len changes after acceptance have no effect.
- Results hold until the next accepted start or reset.
- Reset asserted mid-RUN aborts the window: no done pulse, all results go to 0.
- When first_err_idx=0 and err_cnt=0, there is no valid first error; read err_cnt to tell this apart from a first error at index 0.

Test Plan:
- Reset, then start with win_len=8 and bus_in=0 throughout → busy high for 8 cycles, done pulses 9 cycles after start, pass=1, err_cnt=0, err_bits_acc=0.
- win_len=8 with bit 17 set only on sample 3 → pass=0, err_cnt=1, first_err_idx=3, first_err_bits=err_bits_acc=1<<17.
- win_len=10 with bit 0 set on sample 2 and bit 39 set on samples 5 and 9 (the last sample) → err_cnt=3, first_err_idx=2, first_err_bits=1<<0, err_bits_acc=bits {39,0}, pass=0.
- win_len=0 → done one cycle after start, pass=1, err_cnt=0; a second start pulse during DONE is ignored (state IDLE after, busy=0).
- CNT_W=4, win_len=15 with bus_in all-ones every sample → err_cnt saturates at 15, err_bits_acc all-ones; a start pulse issued mid-window is ignored (window still ends after 15 samples).
- Mismatch on sample 1, then rst=1 at sample 4 → no done pulse; the next cycle shows all outputs 0 and IDLE; a new clean window then yields pass=1.

Source files
------------

// File: rtl/tieoff_bus_checker_if.sv
// Handshake and result bundle between a check-window controller and the
// tie-off bus checker. The master starts windows and drives the monitored
// bus; the slave (the checker) reports status and results.
interface tieoff_bus_checker_if #(
    parameter int WIDTH = 40,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic [WIDTH-1:0] bus_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic [WIDTH-1:0] first_err_bits;
    logic [WIDTH-1:0] err_bits_acc;

    modport master (
        output start, win_len, bus_in,
        input  busy, done, pass, err_cnt, first_err_idx, first_err_bits, err_bits_acc
    );

    modport slave (
        input  start, win_len, bus_in,
        output busy, done, pass, err_cnt, first_err_idx, first_err_bits, err_bits_acc
    );
endinterface

// File: rtl/tieoff_bus_checker.sv
// Receiving-end monitor for a constant tie-off bus. Over a programmed window
// it samples the bus once per clock, compares it with EXPECT and reports
// pass/fail, a saturating mismatch count, the first offending sample and a
// sticky OR of every bit that ever differed.
module tieoff_bus_checker #(
    parameter int               WIDTH  = 40,
    parameter logic [WIDTH-1:0] EXPECT = {WIDTH{1'b0}},
    parameter int               CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    tieoff_bus_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [WIDTH-1:0] first_err_bits_q, first_err_bits_d;
    logic [WIDTH-1:0] err_bits_acc_q, err_bits_acc_d;
    logic             seen_err_q, seen_err_d;
    logic             pass_q, pass_d;

    // Sample is compared directly against the constant; no input register stage.
    logic [WIDTH-1:0] mism_bits;
    logic             mism;
    logic             last_sample;

    assign mism_bits   = bus.bus_in ^ EXPECT;
    assign mism        = |mism_bits;
    assign last_sample = (sample_cnt_q == (len_q - CNT_W'(1)));

    // State register; synchronous reset wins over every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of its peers, independent of block order.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a zero-length window skips RUN entirely.
    always_comb begin
        // NOTE: a default assignment before the case keeps this combinational
        // process from inferring a latch on paths that do not assign state_d.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.win_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_sample) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        bus.busy = (state_q == S_RUN);
        bus.done = (state_q == S_DONE);
    end

    // Datapath next-state: window setup on accepted start, accumulation in RUN.
    always_comb begin
        len_d            = len_q;
        sample_cnt_d     = sample_cnt_q;
        err_cnt_d        = err_cnt_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_bits_d = first_err_bits_q;
        err_bits_acc_d   = err_bits_acc_q;
        seen_err_d       = seen_err_q;
        pass_d           = pass_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d            = bus.win_len;
                    sample_cnt_d     = '0;
                    err_cnt_d        = '0;
                    first_err_idx_d  = '0;
                    first_err_bits_d = '0;
                    err_bits_acc_d   = '0;
                    seen_err_d       = 1'b0;
                    // An empty window trivially passes.
                    pass_d           = (bus.win_len == '0);
                end
            end
            S_RUN: begin
                if (mism) begin
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    err_bits_acc_d = err_bits_acc_q | mism_bits;
                    if (!seen_err_q) begin
                        first_err_idx_d  = sample_cnt_q;
                        first_err_bits_d = mism_bits;
                        seen_err_d       = 1'b1;
                    end
                end
                if (last_sample) begin
                    // The final sample's own mismatch must count against pass.
                    pass_d = !(seen_err_q || mism);
                end else begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset clears every result so an aborted window reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q            <= '0;
            sample_cnt_q     <= '0;
            err_cnt_q        <= '0;
            first_err_idx_q  <= '0;
            first_err_bits_q <= '0;
            err_bits_acc_q   <= '0;
            seen_err_q       <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            len_q            <= len_d;
            sample_cnt_q     <= sample_cnt_d;
            err_cnt_q        <= err_cnt_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_bits_q <= first_err_bits_d;
            err_bits_acc_q   <= err_bits_acc_d;
            seen_err_q       <= seen_err_d;
            pass_q           <= pass_d;
        end
    end

    // Result outputs straight from their registers.
    always_comb begin
        bus.pass           = pass_q;
        bus.err_cnt        = err_cnt_q;
        bus.first_err_idx  = first_err_idx_q;
        bus.first_err_bits = first_err_bits_q;
        bus.err_bits_acc   = err_bits_acc_q;
    end

endmodule

// File: tb/tb_tieoff_bus_checker.sv
// Directed bench for tieoff_bus_checker: a default 40/16 instance for the
// functional scenarios and a CNT_W=4 instance for counter saturation.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_tieoff_bus_checker;

    localparam int W  = 40;
    localparam int CW = 16;
    localparam int CS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] pat [0:15];

    tieoff_bus_checker_if #(.WIDTH(W), .CNT_W(CW)) bus_l ();
    tieoff_bus_checker_if #(.WIDTH(W), .CNT_W(CS)) bus_s ();

    tieoff_bus_checker #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    tieoff_bus_checker #(.WIDTH(W), .CNT_W(CS)) u_dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    always #5 clk = ~clk;

    // Start a window of n samples on the large instance, feeding pat[i] as
    // sample i, and check busy/done cycle by cycle. Returns at the done cycle.
    task automatic run_window(input int n, input string tag);
        bus_l.start   = 1'b1;
        bus_l.win_len = CW'(n);
        bus_l.bus_in  = '0;
        @(negedge clk);
        bus_l.start   = 1'b0;
        bus_l.win_len = CW'(3);  // later changes must not matter
        for (int i = 0; i < n; i++) begin
            bus_l.bus_in = pat[i];
            n_checks++;
            if (bus_l.busy !== 1'b1 || bus_l.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy/done sample %0d: got busy=%b done=%b, want busy=1 done=0", tag, i, bus_l.busy, bus_l.done);
            end
            @(negedge clk);
        end
        bus_l.bus_in = '0;
        n_checks++;
        if (bus_l.done !== 1'b1 || bus_l.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done pulse: got done=%b busy=%b, want done=1 busy=0", tag, bus_l.done, bus_l.busy);
        end
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 16; i++) pat[i] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus_l.busy, bus_l.done, bus_l.pass} !== 3'b000 || bus_l.err_cnt !== '0 ||
            bus_l.first_err_idx !== '0 || bus_l.first_err_bits !== '0 || bus_l.err_bits_acc !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b cnt=%0d idx=%0d fb=%h acc=%h, want all 0",
                     bus_l.busy, bus_l.done, bus_l.pass, bus_l.err_cnt, bus_l.first_err_idx,
                     bus_l.first_err_bits, bus_l.err_bits_acc);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_window();
        clear_pat();
        run_window(8, "clean");
        n_checks++;
        if (bus_l.pass !== 1'b1 || bus_l.err_cnt !== '0 || bus_l.err_bits_acc !== '0) begin
            n_fail++;
            $display("FAIL clean_result: pass=%b cnt=%0d acc=%h, want pass=1 cnt=0 acc=0", bus_l.pass, bus_l.err_cnt, bus_l.err_bits_acc);
        end
        @(negedge clk);
        n_checks++;
        if (bus_l.done !== 1'b0 || bus_l.busy !== 1'b0 || bus_l.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_after_done: done=%b busy=%b pass=%b, want 0 0 1", bus_l.done, bus_l.busy, bus_l.pass);
        end
    endtask

    task automatic test_single_error();
        clear_pat();
        pat[3] = 40'h00_0002_0000;  // bit 17
        run_window(8, "single");
        n_checks++;
        if (bus_l.pass !== 1'b0 || bus_l.err_cnt !== 16'd1 || bus_l.first_err_idx !== 16'd3) begin
            n_fail++;
            $display("FAIL single_counts: pass=%b cnt=%0d idx=%0d, want pass=0 cnt=1 idx=3", bus_l.pass, bus_l.err_cnt, bus_l.first_err_idx);
        end
        n_checks++;
        if (bus_l.first_err_bits !== 40'h00_0002_0000 || bus_l.err_bits_acc !== 40'h00_0002_0000) begin
            n_fail++;
            $display("FAIL single_bits: fb=%h acc=%h, want both 0000020000", bus_l.first_err_bits, bus_l.err_bits_acc);
        end
        @(negedge clk);
    endtask

    task automatic test_multi_error();
        clear_pat();
        pat[2] = 40'h00_0000_0001;
        pat[5] = 40'h80_0000_0000;
        pat[9] = 40'h80_0000_0000;  // final sample
        run_window(10, "multi");
        n_checks++;
        if (bus_l.pass !== 1'b0 || bus_l.err_cnt !== 16'd3 || bus_l.first_err_idx !== 16'd2) begin
            n_fail++;
            $display("FAIL multi_counts: pass=%b cnt=%0d idx=%0d, want pass=0 cnt=3 idx=2", bus_l.pass, bus_l.err_cnt, bus_l.first_err_idx);
        end
        n_checks++;
        if (bus_l.first_err_bits !== 40'h00_0000_0001 || bus_l.err_bits_acc !== 40'h80_0000_0001) begin
            n_fail++;
            $display("FAIL multi_bits: fb=%h acc=%h, want fb=0000000001 acc=8000000001", bus_l.first_err_bits, bus_l.err_bits_acc);
        end
        @(negedge clk);
    endtask

    task automatic test_last_only_error();
        clear_pat();
        pat[4] = 40'h00_1000_0000;  // only the final sample is bad
        run_window(5, "last_only");
        n_checks++;
        if (bus_l.pass !== 1'b0 || bus_l.err_cnt !== 16'd1 || bus_l.first_err_idx !== 16'd4) begin
            n_fail++;
            $display("FAIL last_only: pass=%b cnt=%0d idx=%0d, want pass=0 cnt=1 idx=4", bus_l.pass, bus_l.err_cnt, bus_l.first_err_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        bus_l.start   = 1'b1;
        bus_l.win_len = '0;
        @(negedge clk);
        n_checks++;
        if (bus_l.done !== 1'b1 || bus_l.busy !== 1'b0 || bus_l.pass !== 1'b1 || bus_l.err_cnt !== '0) begin
            n_fail++;
            $display("FAIL zero_len_done: done=%b busy=%b pass=%b cnt=%0d, want 1 0 1 0", bus_l.done, bus_l.busy, bus_l.pass, bus_l.err_cnt);
        end
        // start held in DONE with a non-zero length must be ignored
        bus_l.win_len = CW'(5);
        @(negedge clk);
        bus_l.start = 1'b0;
        n_checks++;
        if (bus_l.busy !== 1'b0 || bus_l.done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_start_in_done: busy=%b done=%b, want 0 0", bus_l.busy, bus_l.done);
        end
        @(negedge clk);
        n_checks++;
        if (bus_l.busy !== 1'b0 || bus_l.done !== 1'b0 || bus_l.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len_idle: busy=%b done=%b pass=%b, want 0 0 1", bus_l.busy, bus_l.done, bus_l.pass);
        end
    endtask

    task automatic test_saturation();
        bus_s.start   = 1'b1;
        bus_s.win_len = 4'd15;
        bus_s.bus_in  = '1;
        @(negedge clk);
        bus_s.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus_s.start   = (i == 7);  // must be ignored while busy
            bus_s.win_len = (i == 7) ? 4'd2 : 4'd15;
            n_checks++;
            if (bus_s.busy !== 1'b1 || bus_s.done !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_busy sample %0d: busy=%b done=%b, want 1 0", i, bus_s.busy, bus_s.done);
            end
            @(negedge clk);
        end
        bus_s.start  = 1'b0;
        bus_s.bus_in = '0;
        n_checks++;
        if (bus_s.done !== 1'b1 || bus_s.err_cnt !== 4'd15 || bus_s.err_bits_acc !== {W{1'b1}} || bus_s.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_result: done=%b cnt=%0d acc=%h pass=%b, want done=1 cnt=15 acc=ffffffffff pass=0",
                     bus_s.done, bus_s.err_cnt, bus_s.err_bits_acc, bus_s.pass);
        end
        n_checks++;
        if (bus_s.first_err_idx !== 4'd0 || bus_s.first_err_bits !== {W{1'b1}}) begin
            n_fail++;
            $display("FAIL sat_first: idx=%0d fb=%h, want idx=0 fb=ffffffffff", bus_s.first_err_idx, bus_s.first_err_bits);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bus_l.start   = 1'b1;
        bus_l.win_len = CW'(8);
        bus_l.bus_in  = '0;
        @(negedge clk);
        bus_l.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_l.bus_in = (i == 1) ? 40'h00_0000_0020 : '0;
            @(negedge clk);
        end
        bus_l.bus_in = '0;
        n_checks++;
        if (bus_l.err_cnt !== 16'd1 || bus_l.first_err_idx !== 16'd1 || bus_l.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: cnt=%0d idx=%0d busy=%b, want cnt=1 idx=1 busy=1", bus_l.err_cnt, bus_l.first_err_idx, bus_l.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus_l.busy, bus_l.done, bus_l.pass} !== 3'b000 || bus_l.err_cnt !== '0 ||
            bus_l.first_err_idx !== '0 || bus_l.first_err_bits !== '0 || bus_l.err_bits_acc !== '0) begin
            n_fail++;
            $display("FAIL abort_cleared: busy=%b done=%b pass=%b cnt=%0d idx=%0d fb=%h acc=%h, want all 0",
                     bus_l.busy, bus_l.done, bus_l.pass, bus_l.err_cnt, bus_l.first_err_idx,
                     bus_l.first_err_bits, bus_l.err_bits_acc);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus_l.done !== 1'b0 || bus_l.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done cycle %0d: done=%b busy=%b, want 0 0", i, bus_l.done, bus_l.busy);
            end
            @(negedge clk);
        end
        clear_pat();
        run_window(4, "after_abort");
        n_checks++;
        if (bus_l.pass !== 1'b1 || bus_l.err_cnt !== '0) begin
            n_fail++;
            $display("FAIL after_abort_result: pass=%b cnt=%0d, want pass=1 cnt=0", bus_l.pass, bus_l.err_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        bus_l.start = 1'b0; bus_l.win_len = '0; bus_l.bus_in = '0;
        bus_s.start = 1'b0; bus_s.win_len = '0; bus_s.bus_in = '0;
        @(negedge clk);
        test_reset();
        test_clean_window();
        test_single_error();
        test_multi_error();
        test_last_only_error();
        test_zero_len();
        test_saturation();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
